commit_queue: RTL and testbench

In-order commit queue feeding the commit stage: it holds issued scoreboard entries and collects their write-back results and exceptions. It presents the `NR_COMMIT_PORTS` oldest entries as `commit_instr_o` and retires them on `commit_ack_i`. It is the producer side of the commit interface, sitting between issue/write-back and the commit stage.

---
 rtl/ariane_pkg.sv | 23 ++
 rtl/commit_queue.sv | 133 +++++++++++++
 tb/tb_commit_queue.sv | 350 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariane_pkg.sv
// Shared core types used by the issue, write-back and commit logic.
package ariane_pkg;

  // Default commit queue depth, also used by the issue logic to size transaction ids.
  localparam int unsigned COMMIT_QUEUE_DEPTH = 8;
  localparam int unsigned TRANS_ID_BITS      = $clog2(COMMIT_QUEUE_DEPTH);

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception_t;

  typedef struct packed {
    logic [63:0]              pc;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [4:0]               rd;
    logic [63:0]              result;
    logic                     valid;
    exception_t               ex;
  } scoreboard_entry_t;

endpackage

// File: rtl/commit_queue.sv
// In-order commit queue: allocates entries at issue, collects write-back results and
// exceptions, and presents the oldest entries to the commit stage for retirement.
module commit_queue
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES      = COMMIT_QUEUE_DEPTH,
  parameter int unsigned NR_COMMIT_PORTS = 2,
  parameter int unsigned NR_WB_PORTS     = 4,
  localparam int unsigned IdxW           = $clog2(NR_ENTRIES),
  localparam int unsigned CntW           = IdxW + 1
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     flush_i,
  input  logic                                     issue_valid_i,
  input  scoreboard_entry_t                        issue_instr_i,
  output logic                                     issue_ready_o,
  output logic [IdxW-1:0]                          issue_trans_id_o,
  input  logic [NR_WB_PORTS-1:0]                   wb_valid_i,
  input  logic [NR_WB_PORTS-1:0][IdxW-1:0]         wb_trans_id_i,
  input  logic [NR_WB_PORTS-1:0][63:0]             wb_result_i,
  input  exception_t [NR_WB_PORTS-1:0]             wb_ex_i,
  output scoreboard_entry_t [NR_COMMIT_PORTS-1:0]  commit_instr_o,
  input  logic [NR_COMMIT_PORTS-1:0]               commit_ack_i,
  output logic [CntW-1:0]                          count_o
);

  scoreboard_entry_t mem_q [NR_ENTRIES];
  scoreboard_entry_t mem_d [NR_ENTRIES];
  logic [NR_ENTRIES-1:0] busy_q, busy_d;
  logic [IdxW-1:0]       head_q, head_d, tail_q, tail_d;
  logic [CntW-1:0]       count_q, count_d;
  logic [IdxW-1:0]       commit_idx [NR_COMMIT_PORTS];
  logic                  issue_fire;
  logic                  retire_run;
  logic [CntW-1:0]       retire_cnt;

  assign issue_ready_o    = (count_q != CntW'(NR_ENTRIES));
  assign issue_trans_id_o = tail_q;
  assign count_o          = count_q;
  assign issue_fire       = issue_valid_i && issue_ready_o;

  // Present the oldest entries; an entry is committable only while its slot is busy.
  always_comb begin
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      commit_idx[k]           = head_q + IdxW'(k);
      commit_instr_o[k]       = mem_q[commit_idx[k]];
      commit_instr_o[k].valid = busy_q[commit_idx[k]] && mem_q[commit_idx[k]].valid;
    end
  end

  // Next-state: write-back, retire, issue, then flush overriding pointer/busy state.
  always_comb begin
    mem_d      = mem_q;
    busy_d     = busy_q;
    retire_run = 1'b1;
    retire_cnt = '0;

    // Later ports overwrite earlier ones, so the highest port index wins a collision.
    for (int s = 0; s < NR_ENTRIES; s++) begin
      for (int p = 0; p < NR_WB_PORTS; p++) begin
        if (wb_valid_i[p] && (wb_trans_id_i[p] == IdxW'(s)) && busy_q[s]) begin
          mem_d[s].result = wb_result_i[p];
          mem_d[s].valid  = 1'b1;
          if (wb_ex_i[p].valid) mem_d[s].ex = wb_ex_i[p];
        end
      end
    end

    // Retire a contiguous prefix of acked, valid entries starting at the head.
    for (int k = 0; k < NR_COMMIT_PORTS; k++) begin
      if (retire_run && commit_ack_i[k] && commit_instr_o[k].valid) begin
        busy_d[commit_idx[k]] = 1'b0;
        retire_cnt            = retire_cnt + CntW'(1);
      end else begin
        retire_run = 1'b0;
      end
    end

    // A full queue never issues, so the tail slot cannot be one being retired.
    if (issue_fire) begin
      mem_d[tail_q]          = issue_instr_i;
      mem_d[tail_q].trans_id = TRANS_ID_BITS'(tail_q);
      mem_d[tail_q].valid    = issue_instr_i.ex.valid;
      busy_d[tail_q]         = 1'b1;
    end

    head_d  = head_q + retire_cnt[IdxW-1:0];
    tail_d  = tail_q + IdxW'(issue_fire);
    count_d = count_q + CntW'(issue_fire) - retire_cnt;

    if (flush_i) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      busy_q  <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      busy_q  <= busy_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Payload storage, not reset; busy bits qualify its contents.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

`ifndef SYNTHESIS
  for (genvar k = 0; k < NR_COMMIT_PORTS; k++) begin : g_ack_chk
    ack_on_invalid: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
      commit_ack_i[k] |-> commit_instr_o[k].valid);
  end
  for (genvar p = 0; p < NR_WB_PORTS; p++) begin : g_wb_chk_p
    for (genvar q = p + 1; q < NR_WB_PORTS; q++) begin : g_wb_chk_q
      wb_same_slot: assert property (@(posedge clk_i) disable iff (rst_i || flush_i)
        !(wb_valid_i[p] && wb_valid_i[q] && (wb_trans_id_i[p] == wb_trans_id_i[q])));
    end
  end
`endif

endmodule

// File: tb/tb_commit_queue.sv
// Scenario bench for commit_queue: expected entries are queued at issue and compared at retire.
module tb_commit_queue;
  import ariane_pkg::*;

  localparam int unsigned N  = 8;
  localparam int unsigned NC = 2;
  localparam int unsigned NW = 4;
  localparam int unsigned IW = 3;

  logic                          clk = 1'b0;
  logic                          rst, flush, issue_valid;
  scoreboard_entry_t             issue_instr;
  logic                          issue_ready;
  logic [IW-1:0]                 issue_tid;
  logic [NW-1:0]                 wb_valid;
  logic [NW-1:0][IW-1:0]         wb_tid;
  logic [NW-1:0][63:0]           wb_result;
  exception_t [NW-1:0]           wb_ex;
  scoreboard_entry_t [NC-1:0]    commit_instr;
  logic [NC-1:0]                 ack;
  logic [IW:0]                   count;

  typedef struct {
    logic [63:0]   pc;
    logic [IW-1:0] tid;
    bit            chk_result;
  } exp_t;

  exp_t          sb[$];
  logic [IW-1:0] model_tail;
  int            errors = 0;
  int            checks = 0;

  always #5 clk = ~clk;

  commit_queue #(
    .NR_ENTRIES     (N),
    .NR_COMMIT_PORTS(NC),
    .NR_WB_PORTS    (NW)
  ) dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .flush_i         (flush),
    .issue_valid_i   (issue_valid),
    .issue_instr_i   (issue_instr),
    .issue_ready_o   (issue_ready),
    .issue_trans_id_o(issue_tid),
    .wb_valid_i      (wb_valid),
    .wb_trans_id_i   (wb_tid),
    .wb_result_i     (wb_result),
    .wb_ex_i         (wb_ex),
    .commit_instr_o  (commit_instr),
    .commit_ack_i    (ack),
    .count_o         (count)
  );

  function automatic logic [63:0] res_of(input logic [63:0] pc);
    return {pc[31:0], ~pc[31:0]};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    issue_valid = 1'b0;
    issue_instr = '0;
    wb_valid    = '0;
    wb_tid      = '0;
    wb_result   = '0;
    wb_ex       = '0;
    ack         = '0;
  endtask

  task automatic do_issue(input logic [63:0] pc, input bit exv, input logic [63:0] cause);
    checks++;
    if (issue_tid !== model_tail) begin
      errors++;
      $display("FAIL issue_trans_id: got %0d want %0d", issue_tid, model_tail);
    end
    issue_instr          = '0;
    issue_instr.pc       = pc;
    issue_instr.rd       = pc[4:0];
    issue_instr.valid    = 1'b1;   // must be cleared by the queue
    issue_instr.trans_id = 3'd5;   // must be overwritten by the queue
    issue_instr.ex.valid = exv;
    issue_instr.ex.cause = cause;
    issue_valid          = 1'b1;
    sb.push_back('{pc: pc, tid: model_tail, chk_result: !exv});
    model_tail = model_tail + 3'd1;
    step();
    issue_valid = 1'b0;
  endtask

  task automatic do_wb(input int port, input logic [IW-1:0] tid, input logic [63:0] r);
    wb_valid[port]  = 1'b1;
    wb_tid[port]    = tid;
    wb_result[port] = r;
    step();
    wb_valid = '0;
  endtask

  task automatic retire_head();
    exp_t e;
    e = sb.pop_front();
    checks++;
    if (commit_instr[0].valid !== 1'b1) begin
      errors++;
      $display("FAIL head_valid: got %b want 1", commit_instr[0].valid);
    end
    checks++;
    if (commit_instr[0].pc !== e.pc) begin
      errors++;
      $display("FAIL head_pc: got %h want %h", commit_instr[0].pc, e.pc);
    end
    checks++;
    if (commit_instr[0].trans_id !== e.tid) begin
      errors++;
      $display("FAIL head_trans_id: got %0d want %0d", commit_instr[0].trans_id, e.tid);
    end
    if (e.chk_result) begin
      checks++;
      if (commit_instr[0].result !== res_of(e.pc)) begin
        errors++;
        $display("FAIL head_result: got %h want %h", commit_instr[0].result, res_of(e.pc));
      end
    end
    ack = 2'b01;
    step();
    ack = '0;
  endtask

  task automatic drain();
    for (int i = 0; i < sb.size(); i++) do_wb(i % NW, sb[i].tid, res_of(sb[i].pc));
    while (sb.size() > 0) retire_head();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL drain_count: got %0d want 0", count);
    end
  endtask

  task automatic check_empty(input string tag);
    checks++;
    if (count !== 4'd0 || issue_ready !== 1'b1 || issue_tid !== 3'd0 ||
        commit_instr[0].valid !== 1'b0 || commit_instr[1].valid !== 1'b0) begin
      errors++;
      $display("FAIL %s: got count=%0d ready=%b tid=%0d v0=%b v1=%b want 0 1 0 0 0", tag,
               count, issue_ready, issue_tid, commit_instr[0].valid, commit_instr[1].valid);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    sb.delete();
    model_tail = '0;
    check_empty("reset_state");
  endtask

  task automatic test_wb_order();
    logic [63:0] pa, pb;
    pa = 64'h100;
    pb = 64'h104;
    do_issue(pa, 1'b0, '0);
    do_issue(pb, 1'b0, '0);
    checks++;
    if (count !== 4'd2 || commit_instr[0].valid !== 1'b0 || commit_instr[1].valid !== 1'b0) begin
      errors++;
      $display("FAIL wb_pre: got count=%0d v0=%b v1=%b want 2 0 0", count,
               commit_instr[0].valid, commit_instr[1].valid);
    end
    do_wb(2, 3'd1, res_of(pb));
    checks++;
    if (commit_instr[0].valid !== 1'b0 || commit_instr[1].valid !== 1'b1) begin
      errors++;
      $display("FAIL wb_b_only: got v0=%b v1=%b want 0 1", commit_instr[0].valid,
               commit_instr[1].valid);
    end
    do_wb(0, 3'd0, res_of(pa));
    checks++;
    if (commit_instr[0].valid !== 1'b1 || commit_instr[0].pc !== pa ||
        commit_instr[0].result !== res_of(pa) || commit_instr[1].valid !== 1'b1 ||
        commit_instr[1].pc !== pb || commit_instr[1].result !== res_of(pb)) begin
      errors++;
      $display("FAIL wb_both: got v0=%b pc0=%h v1=%b pc1=%h want 1 %h 1 %h",
               commit_instr[0].valid, commit_instr[0].pc, commit_instr[1].valid,
               commit_instr[1].pc, pa, pb);
    end
    ack = 2'b11;
    step();
    ack = '0;
    sb.delete();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL dual_ack_count: got %0d want 0", count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < 8; i++) do_issue(64'h200 + 64'(4 * i), 1'b0, '0);
    checks++;
    if (issue_ready !== 1'b0 || count !== 4'd8) begin
      errors++;
      $display("FAIL full: got ready=%b count=%0d want 0 8", issue_ready, count);
    end
    do_wb(1, sb[0].tid, res_of(sb[0].pc));
    issue_instr    = '0;
    issue_instr.pc = 64'hdead;
    issue_valid    = 1'b1;
    ack            = 2'b01;
    step();
    issue_valid = 1'b0;
    ack         = '0;
    void'(sb.pop_front());
    checks++;
    if (count !== 4'd7 || issue_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_ack_blocks_issue: got count=%0d ready=%b want 7 1", count, issue_ready);
    end
    checks++;
    if (commit_instr[0].pc !== sb[0].pc) begin
      errors++;
      $display("FAIL full_head_adv: got %h want %h", commit_instr[0].pc, sb[0].pc);
    end
    drain();
  endtask

  task automatic test_exception();
    do_issue(64'h300, 1'b1, 64'd2);
    checks++;
    if (commit_instr[0].valid !== 1'b1 || commit_instr[0].ex.valid !== 1'b1 ||
        commit_instr[0].ex.cause !== 64'd2) begin
      errors++;
      $display("FAIL pre_exception: got v=%b exv=%b cause=%0d want 1 1 2",
               commit_instr[0].valid, commit_instr[0].ex.valid, commit_instr[0].ex.cause);
    end
    retire_head();
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL exception_retire: got count=%0d want 0", count);
    end
  endtask

  task automatic test_wrap();
    for (int r = 0; r < 20; r++) begin
      for (int j = 0; j < 3; j++) do_issue(64'h1000 + 64'(r * 16 + j * 4), 1'b0, '0);
      for (int j = 0; j < 3; j++) begin
        wb_valid[j]  = 1'b1;
        wb_tid[j]    = sb[j].tid;
        wb_result[j] = res_of(sb[j].pc);
      end
      step();
      wb_valid = '0;
      for (int j = 0; j < 3; j++) retire_head();
    end
    checks++;
    if (count !== 4'd0) begin
      errors++;
      $display("FAIL wrap_count: got %0d want 0", count);
    end
  endtask

  task automatic test_bad_ack();
    do_issue(64'h400, 1'b0, '0);
    do_issue(64'h404, 1'b0, '0);
    wb_valid[0]  = 1'b1;
    wb_tid[0]    = sb[0].tid;
    wb_result[0] = res_of(sb[0].pc);
    wb_valid[1]  = 1'b1;
    wb_tid[1]    = sb[1].tid;
    wb_result[1] = res_of(sb[1].pc);
    step();
    wb_valid = '0;
    ack = 2'b10;
    step();
    ack = '0;
    checks++;
    if (count !== 4'd2 || commit_instr[0].pc !== sb[0].pc || commit_instr[1].pc !== sb[1].pc) begin
      errors++;
      $display("FAIL ack1_alone: got count=%0d pc0=%h want 2 %h", count, commit_instr[0].pc,
               sb[0].pc);
    end
    do_wb(3, model_tail, 64'hbad);
    checks++;
    if (count !== 4'd2 || commit_instr[0].valid !== 1'b1 || commit_instr[1].valid !== 1'b1) begin
      errors++;
      $display("FAIL wb_free_slot: got count=%0d v0=%b v1=%b want 2 1 1", count,
               commit_instr[0].valid, commit_instr[1].valid);
    end
    retire_head();
    retire_head();
  endtask

  task automatic load_five();
    for (int i = 0; i < 5; i++) do_issue(64'h500 + 64'(4 * i), 1'b0, '0);
    do_wb(0, sb[0].tid, res_of(sb[0].pc));
    issue_instr    = '0;
    issue_instr.pc = 64'hbeef;
    issue_valid    = 1'b1;
    wb_valid[2]    = 1'b1;
    wb_tid[2]      = sb[1].tid;
    wb_result[2]   = 64'h1;
    ack            = 2'b01;
  endtask

  task automatic test_flush();
    load_five();
    flush = 1'b1;
    step();
    idle_inputs();
    sb.delete();
    model_tail = '0;
    check_empty("flush_state");
    load_five();
    rst = 1'b1;
    step();
    rst = 1'b0;
    idle_inputs();
    sb.delete();
    model_tail = '0;
    check_empty("reset_mid_state");
    do_issue(64'h600, 1'b0, '0);
    do_wb(3, sb[0].tid, res_of(sb[0].pc));
    retire_head();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    model_tail = '0;
    test_reset();
    test_wb_order();
    test_full();
    test_exception();
    test_wrap();
    test_bad_ack();
    test_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
